rst_seq_ctrl: RTL and testbench

//  Board-level reset sequencer. Sits between the clocking block and the core.

---
 rtl/rst_seq_ctrl_pkg.sv | 12 +
 rtl/rst_seq_ctrl_if.sv | 22 ++
 rtl/rst_seq_ctrl_debounce.sv | 46 ++++
 rtl/rst_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types for the board reset sequencer.
// State encoding is fixed because the core status register reports it.
package rst_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Reset sequencer bundle: raw requests, lock and cause clear in; domain resets, busy, cause out.
interface rst_seq_ctrl_if #(
    parameter int N_SRC = 2,
    parameter int N_DOM = 3
);
    logic [N_SRC-1:0] rst_req;
    logic             locked;
    logic             cause_clr;
    logic [N_DOM-1:0] rst_dom_n;
    logic             busy;
    logic [N_SRC:0]   rst_cause;

    modport master (
        output rst_req, locked, cause_clr,
        input  rst_dom_n, busy, rst_cause
    );

    modport slave (
        input  rst_req, locked, cause_clr,
        output rst_dom_n, busy, rst_cause
    );
endinterface

// File: rtl/rst_seq_ctrl_debounce.sv
// Two-flop synchroniser plus stability debounce for one raw reset request.
// active is the debounced request, normalised to active high.
module rst_seq_ctrl_debounce #(
    parameter int DEB_CYCLES = 12000,
    parameter bit ACT_HI     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic active
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("rst_seq_ctrl_debounce: DEB_CYCLES must be >= 1");
    end

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= ~ACT_HI;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DEB_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign active = stable ^ ~ACT_HI;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Board reset sequencer: merges debounced requests with MMCM lock, holds all
// domains in reset, releases them in order and records the cause of the last reset.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int               N_SRC       = 2,
    parameter int               N_DOM       = 3,
    parameter logic [N_SRC-1:0] SRC_ACT_HI  = '1,
    parameter int               DEB_CYCLES  = 12000,
    parameter int               HOLD_CYCLES = 256,
    parameter int               STEP_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    rst_seq_ctrl_if.slave bus
);
    // state     | meaning
    // WAIT_LOCK | all domains in reset, waiting for lock and no request
    // HOLD      | all domains in reset, counting the hold time
    // RELEASE   | releasing domain k every STEP_CYCLES
    // RUN       | all domains released

    if (N_DOM < 1 || STEP_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
        $error("rst_seq_ctrl: N_DOM, STEP_CYCLES and HOLD_CYCLES must be >= 1");
    end

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam int KW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(STEP_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N_DOM - 1);

    logic [N_SRC-1:0] req_vec;
    logic             req_any;
    logic             lock_s1;
    logic             locked_s;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        rst_seq_ctrl_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .ACT_HI     (SRC_ACT_HI[i])
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (bus.rst_req[i]),
            .active (req_vec[i])
        );
    end

    assign req_any = |req_vec;

    seq_state_e       state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [SW-1:0]    step_q, step_d;
    logic [KW-1:0]    k_q, k_d;
    logic [N_DOM-1:0] rst_dom_q, rst_dom_d;
    logic [N_SRC:0]   cause_q;
    logic             capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_s1   <= 1'b0;
            locked_s  <= 1'b0;
            state_q   <= WAIT_LOCK;
            hold_q    <= '0;
            step_q    <= '0;
            k_q       <= '0;
            rst_dom_q <= '0;
            cause_q   <= '0;
        end else begin
            lock_s1   <= bus.locked;
            locked_s  <= lock_s1;
            state_q   <= state_d;
            hold_q    <= hold_d;
            step_q    <= step_d;
            k_q       <= k_d;
            rst_dom_q <= rst_dom_d;
            // A clear coinciding with a capture keeps only the new bits
            cause_q   <= (bus.cause_clr ? '0 : cause_q) |
                         (capture ? {~locked_s, req_vec} : '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        step_d    = step_q;
        k_d       = k_q;
        rst_dom_d = rst_dom_q;
        capture   = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                rst_dom_d = '0;
                if (locked_s && !req_any) begin
                    state_d = HOLD;
                    hold_d  = HOLD_MAX;
                end
            end
            HOLD: begin
                rst_dom_d = '0;
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (req_any) begin
                    hold_d = HOLD_MAX;
                end else if (hold_q == '0) begin
                    state_d = RELEASE;
                    k_d     = '0;
                    step_d  = STEP_MAX;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            RELEASE: begin
                if (!locked_s || req_any) begin
                    rst_dom_d = '0;
                    capture   = 1'b1;
                    hold_d    = HOLD_MAX;
                    state_d   = locked_s ? HOLD : WAIT_LOCK;
                end else if (step_q == '0) begin
                    rst_dom_d[k_q] = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = RUN;
                    end else begin
                        k_d    = k_q + 1'b1;
                        step_d = STEP_MAX;
                    end
                end else begin
                    step_d = step_q - 1'b1;
                end
            end
            RUN: begin
                rst_dom_d = '1;
                if (!locked_s || req_any) begin
                    rst_dom_d = '0;
                    capture   = 1'b1;
                    state_d   = WAIT_LOCK;
                end
            end
            default: begin
                rst_dom_d = '0;
                state_d   = WAIT_LOCK;
            end
        endcase
    end

    assign bus.rst_dom_n = rst_dom_q;
    assign bus.busy      = ~&rst_dom_q;
    assign bus.rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: expected output changes are queued with
// their cycle when stimulus is driven and matched as the outputs move.
module tb_rst_seq_ctrl;

    typedef struct {
        int         cyc;
        logic [2:0] dom;
        logic       busy;
        logic [2:0] cause;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    logic [6:0] snap;

    rst_seq_ctrl_if #(.N_SRC(2), .N_DOM(3)) bus ();

    rst_seq_ctrl #(
        .N_SRC       (2),
        .N_DOM       (3),
        .SRC_ACT_HI  (2'b01),
        .DEB_CYCLES  (4),
        .HOLD_CYCLES (8),
        .STEP_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] d, input logic [2:0] ca);
        exp_t e;
        e.cyc   = c;
        e.dom   = d;
        e.busy  = ~&d;
        e.cause = ca;
        sb.push_back(e);
    endtask

    // Hold entered at edge t: domains release at t+10, t+12, t+14
    task automatic push_seq(input int t, input logic [2:0] ca);
        push(t + 10, 3'b001, ca);
        push(t + 12, 3'b011, ca);
        push(t + 14, 3'b111, ca);
    endtask

    always @(negedge clk) begin
        if (mon_en && ({bus.rst_dom_n, bus.busy, bus.rst_cause} !== snap)) begin
            exp_t e;
            snap = {bus.rst_dom_n, bus.busy, bus.rst_cause};
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_change cyc=%0d got dom=%b busy=%b cause=%b, required no change",
                       cyc, bus.rst_dom_n, bus.busy, bus.rst_cause);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL change_cycle got %0d required %0d (dom=%b)", cyc, e.cyc, e.dom);
                end
                checks++;
                assert ({bus.rst_dom_n, bus.busy, bus.rst_cause} === {e.dom, e.busy, e.cause}) else begin
                    errors++;
                    $error("FAIL change_value cyc=%0d got dom=%b busy=%b cause=%b required dom=%b busy=%b cause=%b",
                           cyc, bus.rst_dom_n, bus.busy, bus.rst_cause, e.dom, e.busy, e.cause);
                end
            end
        end
    end

    initial begin
        int r, e, l, t, f;
        rst_n         = 1'b0;
        bus.rst_req   = 2'b10;
        bus.locked    = 1'b1;
        bus.cause_clr = 1'b0;

        // 1: reset values, then power-up sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (bus.rst_dom_n === 3'b000) else begin
            errors++; $error("FAIL reset_dom got %b required 000", bus.rst_dom_n);
        end
        checks++;
        assert (bus.busy === 1'b1) else begin
            errors++; $error("FAIL reset_busy got %b required 1", bus.busy);
        end
        checks++;
        assert (bus.rst_cause === 3'b000) else begin
            errors++; $error("FAIL reset_cause got %b required 000", bus.rst_cause);
        end
        snap   = {bus.rst_dom_n, bus.busy, bus.rst_cause};
        mon_en = 1'b1;
        rst_n  = 1'b1;
        r      = cyc;
        push_seq(r + 3, 3'b000);
        repeat (20) @(negedge clk);

        // 2: short glitch is filtered; a held request re-sequences
        bus.rst_req[0] = 1'b1;
        repeat (3) @(negedge clk);
        bus.rst_req[0] = 1'b0;
        repeat (10) @(negedge clk);
        e = cyc;
        bus.rst_req[0] = 1'b1;
        push(e + 7, 3'b000, 3'b001);
        push_seq(e + 17, 3'b001);
        repeat (10) @(negedge clk);
        bus.rst_req[0] = 1'b0;
        repeat (25) @(negedge clk);

        // 3+5: lock loss in RUN with cause clear landing on the capture edge
        e = cyc;
        bus.locked = 1'b0;
        push(e + 3, 3'b000, 3'b100);
        repeat (2) @(negedge clk);
        bus.cause_clr = 1'b1;
        @(negedge clk);
        bus.cause_clr = 1'b0;
        repeat (10) @(negedge clk);
        l = cyc;
        bus.locked = 1'b1;
        t = l + 3;
        push(t + 10, 3'b001, 3'b100);

        // 4: active-low request lands while domain 0 is released
        repeat (7) @(negedge clk);
        bus.rst_req[1] = 1'b0;
        push(t + 11, 3'b000, 3'b110);
        repeat (10) @(negedge clk);
        f = cyc;
        bus.rst_req[1] = 1'b1;
        push(f + 16, 3'b001, 3'b110);
        push(f + 18, 3'b011, 3'b110);

        // 6: synchronous reset in the middle of RELEASE
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        push(f + 19, 3'b000, 3'b000);
        repeat (3) @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        push_seq(r + 3, 3'b000);
        repeat (22) @(negedge clk);

        checks++;
        assert (sb.size() === 0) else begin
            errors++; $error("FAIL pending_changes got %0d required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
